// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings and forwarding select codes.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LU2    = 2'b01,
    ST_FLUSH2 = 2'b10
  } state_e;

  // Forwarding mux selects for the EX-stage operand paths.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  function automatic logic src_hit(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, dmem freeze, perf counters.
// Control outputs are combinational from the registered state and the current inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e state_q, state_d;
  logic   load_use;
  logic   flush_acc;

  assign load_use = ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
                    (src_hit(id_uses_rs1, id_rs1, ex_rd) || src_hit(id_uses_rs2, id_rs2, ex_rd));

  always_comb begin
    state_d     = state_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    flush_acc   = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else if (dmem_busy) begin
      // Freeze: everything holds, including the FSM, until memory completes.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_acc  = 1'b1;
            state_d    = ST_FLUSH2;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_LU2;
          end
        end
        ST_LU2: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          state_d    = ST_RUN;
        end
        ST_FLUSH2: begin
          ifid_flush = 1'b1;
          state_d    = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pc_stall),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_acc),
    .cnt_o (flush_cnt)
  );

endmodule
